fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares the write port of one FIFO instance among N requesters using round-robin, burst-limited grants.
- Converts each requester's req/data into single-beat accept pulses.
- Drives the FIFO's wr_en/data_in from registers and never issues a write the FIFO cannot take.
- Sits directly in front of the FIFO and watches its status flags.

Parameters:
- N_REQ, 4, number of requesters (must be >= 2)
- FIFO_WIDTH, 16, data width per requester and to the FIFO
- BURST_LEN, 4, maximum beats accepted per grant before rotation (>= 1)

Ports:
- clk  in  1  single clock; all state on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*FIFO_WIDTH  requester i data in slice [i*FIFO_WIDTH +: FIFO_WIDTH]
- gnt  out  N_REQ  combinational one-hot accept; the beat transfers in any cycle where req[i]&&gnt[i]
- fifo_wr_en  out  1  registered write enable to the FIFO
- fifo_data  out  FIFO_WIDTH  registered write data to the FIFO
- fifo_full  in  1  FIFO full flag
- fifo_almostfull  in  1  FIFO count == depth-1
- fifo_overflow  in  1  FIFO overflow flag
- owner  out  $clog2(N_REQ)  current or last owner index
- busy  out  1  state == OWN
- ovf_err  out  1  sticky; set when fifo_overflow is observed high

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, fifo_wr_en=0, fifo_data=0, ovf_err=0, gnt=0. Reset overrides everything; an in-progress burst is abandoned with no write issued the next cycle.
- space_ok = !fifo_full && !(fifo_wr_en && fifo_almostfull). This is conservative: it ignores concurrent reads.
- IDLE:
  - gnt=0.
  - If |req: select the first i with req[i], scanning from rr_ptr upward with wrap. Then owner<=i, beat_cnt<=0, go to OWN.
  - Arbitration always costs exactly one cycle.
- OWN:
  - gnt[owner] = req[owner] && space_ok. All other gnt bits are 0.
  - Accept: fifo_wr_en<=1, fifo_data<=req_data slice of owner, beat_cnt<=beat_cnt+1. The write is visible to the FIFO one cycle after the accept.
  - No accept: fifo_wr_en<=0, fifo_data holds.
  - Exit to IDLE with rr_ptr<=(owner+1) mod N_REQ when either condition holds:
    - req[owner]==0 (no accept that cycle), or
    - the accepted beat is the BURST_LEN-th.
  - Stall (req[owner]=1, !space_ok): stay in OWN, gnt=0, beat_cnt holds. There is no timeout.
- In IDLE, fifo_wr_en<=0.
- Widths and wrap:
  - beat_cnt is $clog2(BURST_LEN+1) bits.
  - rr_ptr and owner are $clog2(N_REQ) bits. When N_REQ is not a power of 2, rr_ptr wraps explicitly to 0 after N_REQ-1.
- ovf_err <= ovf_err | fifo_overflow. It clears only on rst.
- busy = (state==OWN). owner holds its value after the return to IDLE.
- Requirement: fifo_wr_en is never 1 in a cycle where fifo_full was 1 in the previous cycle.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, OWN}
  - the rr-pick function (first set bit from a start index, with wrap)
  - localparams for the rr_ptr and beat_cnt widths
- One natural sub-module: rr_pick, a combinational round-robin priority encoder (req vector, start index -> index, found). All sequencing stays in the top.

Test Plan:
Common bench setup: N_REQ=4, FIFO_WIDTH=16, BURST_LEN=4, FIFO depth 8.
1. Only req[1] held, data 0xA000+k.
   - Cycle 0: arbitration.
   - Cycles 1-4: gnt[1]=1.
   - Cycles 2-5: fifo_wr_en=1 with data A000..A003.
   - Cycle 5: IDLE, rr_ptr=2.
   - Cycle 6: req[1] is re-granted after the wrap.
2. All four req high, FIFO read every cycle.
   - Grant order 0,1,2,3,0, each exactly 4 beats.
   - One idle cycle between bursts.
   - No overflow and no underflow at the FIFO.
3. FIFO never read, req[0] held.
   - Exactly 8 writes land (burst 4 + burst 4), then gnt=0 with fifo_wr_en=0 indefinitely.
   - FIFO count stays 8 and fifo_overflow stays 0.
4. req[2] high for 2 accepted beats, then low.
   - Next cycle: IDLE, rr_ptr=3, beat total 2.
   - With req[0] and req[3] both high, req[3] is granted next.
5. rst pulsed during beat 2 of a burst.
   - Next cycle: gnt=0, fifo_wr_en=0, busy=0, owner=0, rr_ptr=0.
   - After release, req[3] alone is granted after one arbitration cycle.
6. fifo_overflow forced to 1 for one cycle.
   - ovf_err=1 from the next cycle and holds through further traffic.
   - rst clears it to 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter: FSM state,
// index-width helpers and the round-robin first-set-bit search.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   // Widest request vector the round-robin search handles.
   localparam int MAX_REQ = 32;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Widths for the default configuration (4 requesters, 4-beat bursts).
   localparam int RR_W   = idx_width(4);
   localparam int BEAT_W = idx_width(4 + 1);

   // First set bit of req[0 +: n], scanning upward from start with wrap;
   // returns -1 when no bit is set.
   function automatic int rr_first(input logic [MAX_REQ-1:0] req,
                                   input int                 n,
                                   input int                 start);
      int pick;
      int idx;
      pick = -32'sd1;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = ((start + k) >= n) ? (start + k - n) : (start + k);
         if ((k < n) && (pick < 32'sd0) && req[idx[4:0]]) begin
            pick = idx;
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above
// the start index, wrapping past N_REQ-1.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = RR_W
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [MAX_REQ-1:0] req_ext_s;
   int                 pick_s;

   // Widen the request vector and run the wrap-around search.
   always_comb begin
      req_ext_s              = '0;
      req_ext_s[N_REQ-1:0]   = req;
      pick_s                 = rr_first(req_ext_s, N_REQ, int'(start));
      found                  = (pick_s >= 32'sd0);
      if (found) begin
         idx = pick_s[IDX_W-1:0];
      end else begin
         idx = '0;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among
// N_REQ requesters; writes are registered and only issued when space is sure.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int BURST_LEN  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            gnt,
   output logic                        fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]       fifo_data,
   input  logic                        fifo_full,
   input  logic                        fifo_almostfull,
   input  logic                        fifo_overflow,
   output logic [$clog2(N_REQ)-1:0]    owner,
   output logic                        busy,
   output logic                        ovf_err
);

   localparam int IW = idx_width(N_REQ);
   localparam int BW = idx_width(BURST_LEN + 1);

   arb_state_e             state_r;
   logic [IW-1:0]          rr_ptr_r;
   logic [IW-1:0]          owner_r;
   logic [BW-1:0]          beat_cnt_r;
   logic                   ovf_err_r;

   logic [IW-1:0]          pick_s;
   logic                   found_s;
   logic                   space_ok_s;
   logic                   owner_req_s;
   logic                   accept_s;
   logic                   last_beat_s;
   logic [IW-1:0]          rr_next_s;
   logic [FIFO_WIDTH-1:0]  owner_data_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IW)
   ) u_rr_pick (
      .req   (req),
      .start (rr_ptr_r),
      .idx   (pick_s),
      .found (found_s)
   );

   // A write already in flight into an almost-full FIFO fills it, so the
   // space check is conservative and never counts on a concurrent read.
   always_comb begin
      space_ok_s  = !fifo_full && !(fifo_wr_en && fifo_almostfull);
      owner_req_s = req[owner_r];
      accept_s    = (state_r == OWN) && owner_req_s && space_ok_s;
      last_beat_s = (beat_cnt_r == BW'(BURST_LEN - 1));
      rr_next_s   = (owner_r == IW'(N_REQ - 1)) ? '0 : (owner_r + IW'(1));
   end

   // Select the owner's data slice.
   always_comb begin
      owner_data_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         owner_data_s = (owner_r == IW'(i)) ? req_data[i*FIFO_WIDTH +: FIFO_WIDTH]
                                            : owner_data_s;
      end
   end

   // One-hot accept towards the owning requester.
   always_comb begin
      gnt = '0;
      if (accept_s) begin
         gnt[owner_r] = 1'b1;
      end else begin
         gnt = '0;
      end
   end

   // Arbitration FSM with registered FIFO write interface.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         rr_ptr_r   <= '0;
         owner_r    <= '0;
         beat_cnt_r <= '0;
         fifo_wr_en <= 1'b0;
         fifo_data  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               fifo_wr_en <= 1'b0;
               if (found_s) begin
                  owner_r    <= pick_s;
                  beat_cnt_r <= '0;
                  state_r    <= OWN;
               end else begin
                  state_r    <= IDLE;
               end
            end
            OWN: begin
               if (accept_s) begin
                  fifo_wr_en <= 1'b1;
                  fifo_data  <= owner_data_s;
                  beat_cnt_r <= beat_cnt_r + BW'(1);
                  if (last_beat_s) begin
                     rr_ptr_r <= rr_next_s;
                     state_r  <= IDLE;
                  end else begin
                     state_r  <= OWN;
                  end
               end else if (!owner_req_s) begin
                  fifo_wr_en <= 1'b0;
                  rr_ptr_r   <= rr_next_s;
                  state_r    <= IDLE;
               end else begin
                  // Stalled on a full FIFO: hold the grant indefinitely.
                  fifo_wr_en <= 1'b0;
                  state_r    <= OWN;
               end
            end
            default: begin
               fifo_wr_en <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   // Sticky overflow observation.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_err_r <= 1'b0;
      end else begin
         ovf_err_r <= ovf_err_r | fifo_overflow;
      end
   end

   assign owner   = owner_r;
   assign busy    = (state_r == OWN);
   assign ovf_err = ovf_err_r;

endmodule
